fetch_sequencer: RTL and testbench

Instruction-fetch front end that drives the instruction memory and hands fetched instructions to decode. It owns the architectural PC and issues one fetch request per cycle to a synchronous-read instruction memory. It captures each returned word, tagged with its PC, into a 3-entry output queue, and presents queue entries to decode over a valid/ready handshake. It sits between the datapath's branch/jump resolution, which drives the redirect input, and the decode stage.

---
 rtl/fetch_sequencer.sv | 95 +++++++++
 tb/tb_fetch_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch front end. Owns the PC, issues one
// request per cycle to a synchronous-read instruction memory, captures each
// returned word with its PC into a 3-entry queue, and hands the queue head
// to decode over a valid/ready handshake.
module fetch_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h00000000
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemData,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic        OutValid,
  output logic [31:0] OutInstr,
  output logic [31:0] OutPC,
  input  logic        OutReady
);

  localparam int unsigned DEPTH = 3;

  logic [31:0] pc;
  logic [31:0] issue_pc;
  logic        in_flight;
  logic [1:0]  head;
  logic [1:0]  tail;
  logic [1:0]  count;
  logic [31:0] q_pc    [DEPTH];
  logic [31:0] q_instr [DEPTH];

  logic [2:0]  occupancy;
  logic        push;
  logic        pop;

  // Wrap a queue pointer modulo the queue depth.
  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Entries already queued plus the one still coming back from memory.
  // Issuing only while this is at most 2 guarantees every response has a slot.
  assign occupancy = {1'b0, count} + {2'b00, in_flight};
  assign ImemReq   = !Reset && !RedirectValid && (occupancy <= 3'd2);
  assign ImemAddr  = pc;

  assign push = in_flight && !RedirectValid && !Reset;
  assign pop  = OutValid && OutReady;

  assign OutValid = (count != 2'd0);
  assign OutInstr = q_instr[head];
  assign OutPC    = q_pc[head];

  // PC, in-flight tracking and queue bookkeeping; reset beats redirect beats normal flow.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (Reset) begin
      pc        <= RESET_ADDR;
      in_flight <= 1'b0;
      head      <= 2'd0;
      tail      <= 2'd0;
      count     <= 2'd0;
    end else if (RedirectValid) begin
      // Flush everything, including the response still in flight.
      pc        <= RedirectTarget & ~32'h3;
      in_flight <= 1'b0;
      head      <= 2'd0;
      tail      <= 2'd0;
      count     <= 2'd0;
    end else begin
      if (ImemReq) begin
        issue_pc  <= pc;
        pc        <= pc + 32'd4;
        in_flight <= 1'b1;
      end else begin
        in_flight <= 1'b0;
      end
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Queue storage: written at the tail when a response arrives.
  always_ff @(posedge Clk) begin
    // NOTE: the queue payload is deliberately not reset; count alone decides
    // which entries are meaningful, so clearing the data would buy nothing.
    if (push) begin
      q_pc[tail]    <= issue_pc;
      q_instr[tail] <= ImemData;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer. A synchronous-read memory
// model returns address ^ A5A5A5A5; a second instance checks PC wraparound
// from a high reset address.
module tb_fetch_sequencer;

  localparam logic [31:0] PAT = 32'hA5A5A5A5;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        RedirectValid;
  logic [31:0] RedirectTarget;
  logic        OutReady;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic [31:0] ImemData;
  logic        OutValid;
  logic [31:0] OutInstr;
  logic [31:0] OutPC;

  logic        hi_req;
  logic [31:0] hi_addr;
  logic [31:0] hi_data;
  logic        hi_valid;
  logic [31:0] hi_instr;
  logic [31:0] hi_pc;
  logic        hi_redirect = 1'b0;
  logic [31:0] hi_target   = 32'h0;
  logic        hi_ready    = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  fetch_sequencer dut (
    .Clk(Clk), .Reset(Reset),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemData(ImemData),
    .RedirectValid(RedirectValid), .RedirectTarget(RedirectTarget),
    .OutValid(OutValid), .OutInstr(OutInstr), .OutPC(OutPC),
    .OutReady(OutReady)
  );

  fetch_sequencer #(.RESET_ADDR(32'hFFFFFFF8)) dut_hi (
    .Clk(Clk), .Reset(Reset),
    .ImemReq(hi_req), .ImemAddr(hi_addr), .ImemData(hi_data),
    .RedirectValid(hi_redirect), .RedirectTarget(hi_target),
    .OutValid(hi_valid), .OutInstr(hi_instr), .OutPC(hi_pc),
    .OutReady(hi_ready)
  );

  // Synchronous-read instruction memories: data appears the cycle after a request.
  always @(posedge Clk) begin
    if (ImemReq) ImemData <= ImemAddr ^ PAT;
    if (hi_req)  hi_data  <= hi_addr ^ PAT;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic cyc(input logic rst, input logic rv, input logic [31:0] tgt, input logic rdy);
    @(negedge Clk);
    Reset          = rst;
    RedirectValid  = rv;
    RedirectTarget = tgt;
    OutReady       = rdy;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc);
    check({tag, "_valid"}, {31'd0, OutValid}, {31'd0, v});
    if (v) begin
      check({tag, "_pc"},    OutPC,    pc);
      check({tag, "_instr"}, OutInstr, pc ^ PAT);
    end
  endtask

  task automatic expect_req(input string tag, input logic r, input logic [31:0] a);
    check({tag, "_req"}, {31'd0, ImemReq}, {31'd0, r});
    if (r) check({tag, "_addr"}, ImemAddr, a);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    check("reset_req", {31'd0, ImemReq}, 32'd0);
  endtask

  initial begin
    logic [31:0] hi_tab [4];
    int          reqs;
    int          xfers;
    hi_tab[0] = 32'hFFFFFFF8;
    hi_tab[1] = 32'hFFFFFFFC;
    hi_tab[2] = 32'h00000000;
    hi_tab[3] = 32'h00000004;

    // Reset state.
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    check("rst_req",     {31'd0, ImemReq},  32'd0);
    check("rst_valid",   {31'd0, OutValid}, 32'd0);
    check("rst_addr",    ImemAddr,          32'h0);
    check("rst_hi_addr", hi_addr,           32'hFFFFFFF8);
    check("rst_hi_req",  {31'd0, hi_req},   32'd0);

    // Streaming with OutReady high: one request and one transfer per cycle.
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      expect_req($sformatf("stream%0d", k), 1'b1, 32'(4 * k));
      if (k >= 2) expect_out($sformatf("stream%0d", k), 1'b1, 32'(4 * (k - 2)));
      else        expect_out($sformatf("stream%0d", k), 1'b0, 32'h0);
      if (k >= 2 && k <= 5) begin
        check($sformatf("hi%0d_valid", k), {31'd0, hi_valid}, 32'd1);
        check($sformatf("hi%0d_pc", k),    hi_pc,    hi_tab[k - 2]);
        check($sformatf("hi%0d_instr", k), hi_instr, hi_tab[k - 2] ^ PAT);
      end
    end

    // Stall: OutReady low for 10 cycles; exactly 3 requests, queue fills.
    do_reset();
    reqs = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      if (ImemReq) reqs++;
      if (k < 3) expect_req($sformatf("stall%0d", k), 1'b1, 32'(4 * k));
      else       expect_req($sformatf("stall%0d", k), 1'b0, 32'h0);
    end
    check("stall_reqs", 32'(reqs), 32'd3);
    expect_out("stall_head", 1'b1, 32'h0);
    for (int k = 10; k < 15; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      expect_out($sformatf("drain%0d", k), 1'b1, 32'(4 * (k - 10)));
      if (k == 10) expect_req("drain10", 1'b0, 32'h0);
      if (k == 11) expect_req("drain11", 1'b1, 32'hC);
    end

    // Redirect with C=2, F=1 (cycle 3 of a stall), then back-to-back redirects.
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h00000103, 1'b0);
    expect_req("redir_r", 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("redir_r1", 1'b0, 32'h0);
    expect_req("redir_r1", 1'b1, 32'h100);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("redir_r2", 1'b0, 32'h0);
    expect_req("redir_r2", 1'b1, 32'h104);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("redir_r3", 1'b1, 32'h100);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("redir_r4", 1'b1, 32'h104);
    cyc(1'b0, 1'b1, 32'h400, 1'b1);
    expect_out("b2b_a", 1'b1, 32'h108);
    expect_req("b2b_a", 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h503, 1'b1);
    expect_out("b2b_b", 1'b0, 32'h0);
    expect_req("b2b_b", 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("b2b_c", 1'b0, 32'h0);
    expect_req("b2b_c", 1'b1, 32'h500);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    expect_req("b2b_d", 1'b1, 32'h504);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("b2b_e", 1'b1, 32'h500);

    // Reset together with redirect while the queue is full.
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    expect_out("full_head", 1'b1, 32'h0);
    expect_req("full", 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h200, 1'b1);
    expect_req("rstredir", 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("rstredir_1", 1'b0, 32'h0);
    expect_req("rstredir_1", 1'b1, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    expect_req("rstredir_2", 1'b1, 32'h4);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    expect_out("rstredir_3", 1'b1, 32'h0);

    // Handshake in the redirect cycle: head delivered once, then only the target.
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
    xfers = 0;
    cyc(1'b0, 1'b1, 32'h300, 1'b1);
    expect_out("hsredir_r", 1'b1, 32'h4);
    if (OutValid && OutReady) xfers++;
    for (int k = 1; k < 4; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (OutValid && OutReady) xfers++;
      if (k < 3) expect_out($sformatf("hsredir_%0d", k), 1'b0, 32'h0);
      else       expect_out($sformatf("hsredir_%0d", k), 1'b1, 32'h300);
      if (k == 1) expect_req("hsredir_1", 1'b1, 32'h300);
    end
    check("hsredir_xfers", 32'(xfers), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
